// File: rtl/mult_sched_pkg.sv
// Shared types for the round-robin multiplier scheduler.
// Holds the FSM state encoding and the requester-index width helper.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_reg.sv
// Registered unsigned bw x bw multiplier, one cycle latency.
// Ports: CLK, RESETn, i_a, i_b in; o_p (2*bw) out.
module mult_reg #(
  parameter int bw = 16
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic [bw-1:0]   i_a,
  input  logic [bw-1:0]   i_b,
  output logic [2*bw-1:0] o_p
);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)
      o_p <= '0;
    else
      o_p <= {{bw{1'b0}}, i_a} * {{bw{1'b0}}, i_b};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit from i_ptr upward.
// Ports: i_req, i_ptr in; o_gnt (one-hot), o_idx, o_any out.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_sum = '0;
    w_j   = '0;
    for (int k = 0; k < NREQ; k++) begin
      // candidate index (ptr + k) mod NREQ
      w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NREQ))
        w_sum = w_sum - (IDW+1)'(NREQ);
      w_j = w_sum[IDW-1:0];
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one registered multiplier among NREQ clients.
// Ports: CLK, RESETn, req_valid/a/b/ready, rsp_valid/id/prod/ready, busy.
module mult_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter  int BW   = 16,
  parameter  int NREQ = 4,
  localparam int IDW  = idw(NREQ)
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*BW-1:0] req_a,
  input  logic [NREQ*BW-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*BW-1:0]   rsp_prod,
  input  logic              rsp_ready,
  output logic              busy
);

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [BW-1:0]   r_a;
  logic [BW-1:0]   r_b;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic            w_take;
  logic [2*BW-1:0] w_prod;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Operand regs hold through DONE, so the product stays stable.
  mult_reg #(.bw(BW)) u_mul (
    .CLK    (CLK),
    .RESETn (RESETn),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_p    (w_prod)
  );

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next = CALC;
          w_take = 1'b1;
        end
      end
      CALC: w_next = DONE;
      DONE: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Gate with RESETn so req_ready drops the moment reset asserts.
  assign req_ready = (r_state == IDLE && RESETn) ? w_gnt : '0;
  assign rsp_valid = (r_state == DONE);
  assign rsp_id    = rsp_valid ? r_id : '0;
  assign rsp_prod  = rsp_valid ? w_prod : '0;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_a   <= req_a[w_idx*BW +: BW];
        r_b   <= req_b[w_idx*BW +: BW];
        r_id  <= w_idx;
        r_ptr <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench for mult_rr_scheduler (BW=16, NREQ=4).
// Random operands checked against a plain round-robin/arithmetic model.
module tb_mult_rr_scheduler;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_prod;
  logic        rsp_ready;
  logic        busy;

  int errs   = 0;
  int checks = 0;
  int m_ptr  = 0;

  mult_rr_scheduler #(.BW(16), .NREQ(4)) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  function automatic int win(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++)
      if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [31:0] lane_prod(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int w);
    logic [15:0] x;
    logic [15:0] y;
    x = a[w*16 +: 16];
    y = b[w*16 +: 16];
    return {16'b0, x} * {16'b0, y};
  endfunction

  function automatic logic [3:0] onehot(input int w);
    return 4'(1 << w);
  endfunction

  task automatic apply_reset();
    RESETn    = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESETn = 1'b1;
    m_ptr = 0;
  endtask

  // One transaction with rsp_ready high; returns what the DUT did.
  task automatic serve(input logic [3:0] mask, input logic [63:0] av,
                       input logic [63:0] bv, output logic [3:0] gnt,
                       output int lat, output logic [1:0] id,
                       output logic [31:0] prod);
    req_valid = mask;
    req_a     = av;
    req_b     = bv;
    rsp_ready = 1'b1;
    #1 gnt = req_ready;
    @(posedge CLK); #1;
    req_valid = '0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      @(posedge CLK); #1;
      lat++;
    end
    id   = rsp_id;
    prod = rsp_prod;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_ctl: rdy=%b vld=%b busy=%b exp 0000 0 0",
               req_ready, rsp_valid, busy);
    end
    checks++;
    if (rsp_id !== 2'd0 || rsp_prod !== 32'd0) begin
      errs++;
      $display("FAIL reset_data: id=%0d prod=%h exp 0 0", rsp_id, rsp_prod);
    end
    RESETn    = 1'b0;
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0) begin
      errs++;
      $display("FAIL reset_rdy_in_reset: got %b exp 0000", req_ready);
    end
    req_valid = '0;
    @(posedge CLK); #1;
    RESETn = 1'b1;
    m_ptr  = 0;
  endtask

  task automatic test_single();
    logic [3:0]  g;
    int          lat;
    logic [1:0]  id;
    logic [31:0] p;
    logic [63:0] av;
    logic [63:0] bv;
    av = '0;
    bv = '0;
    av[32 +: 16] = 16'd3;
    bv[32 +: 16] = 16'd5;
    serve(4'b0100, av, bv, g, lat, id, p);
    checks++;
    if (g !== 4'b0100) begin
      errs++;
      $display("FAIL single_gnt: got %b exp 0100", g);
    end
    checks++;
    if (lat != 1) begin
      errs++;
      $display("FAIL single_lat: got %0d exp 1", lat);
    end
    checks++;
    if (id !== 2'd2 || p !== 32'd15) begin
      errs++;
      $display("FAIL single_rsp: id=%0d prod=%0d exp 2 15", id, p);
    end
    m_ptr = 3;
  endtask

  task automatic test_wrap();
    logic [3:0]  masks [4] = '{4'b0011, 4'b0011, 4'b1001, 4'b1001};
    int          exp_w [4] = '{0, 1, 3, 0};
    logic [3:0]  g;
    int          lat;
    logic [1:0]  id;
    logic [31:0] p;
    logic [63:0] av;
    logic [63:0] bv;
    for (int i = 0; i < 4; i++) begin
      av = {$urandom, $urandom};
      bv = {$urandom, $urandom};
      serve(masks[i], av, bv, g, lat, id, p);
      checks++;
      if (g !== onehot(exp_w[i]) || id !== 2'(exp_w[i])) begin
        errs++;
        $display("FAIL wrap_%0d: gnt=%b id=%0d exp %b %0d",
                 i, g, id, onehot(exp_w[i]), exp_w[i]);
      end
      checks++;
      if (p !== lane_prod(av, bv, exp_w[i])) begin
        errs++;
        $display("FAIL wrap_prod_%0d: got %h exp %h",
                 i, p, lane_prod(av, bv, exp_w[i]));
      end
    end
    m_ptr = 1;
  endtask

  task automatic test_back_to_back();
    int          q_id [$];
    int          nxt = 0;
    int          ngr = 0;
    int          nrsp = 0;
    int          w;
    int          e;
    logic [63:0] av;
    logic [63:0] bv;
    apply_reset();
    av = {$urandom, $urandom};
    bv = {$urandom, $urandom};
    req_a     = av;
    req_b     = bv;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 15; c++) begin
      if (req_ready !== 4'b0) begin
        w = win(4'hF, m_ptr);
        checks++;
        if (req_ready !== onehot(w) || c != nxt) begin
          errs++;
          $display("FAIL b2b_grant: cyc=%0d rdy=%b exp cyc=%0d %b",
                   c, req_ready, nxt, onehot(w));
        end
        q_id.push_back(w);
        m_ptr = (w + 1) % 4;
        nxt   = c + 3;
        ngr++;
      end
      if (rsp_valid === 1'b1) begin
        e = (q_id.size() > 0) ? q_id.pop_front() : -1;
        checks++;
        if (e < 0 || rsp_id !== 2'(e) || rsp_prod !== lane_prod(av, bv, e)) begin
          errs++;
          $display("FAIL b2b_rsp: id=%0d prod=%h exp %0d %h",
                   rsp_id, rsp_prod, e, lane_prod(av, bv, (e < 0) ? 0 : e));
        end
        nrsp++;
      end
      @(posedge CLK); #2;
    end
    req_valid = '0;
    checks++;
    if (ngr != 5 || nrsp != 5) begin
      errs++;
      $display("FAIL b2b_count: grants=%0d rsps=%0d exp 5 5", ngr, nrsp);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_backpressure();
    int w;
    req_a     = {4{16'hFFFF}};
    req_b     = {4{16'hFFFF}};
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    w = win(4'hF, m_ptr);
    #1;
    checks++;
    if (req_ready !== onehot(w)) begin
      errs++;
      $display("FAIL bp_grant: got %b exp %b", req_ready, onehot(w));
    end
    m_ptr = (w + 1) % 4;
    repeat (2) begin
      @(posedge CLK); #1;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_prod !== 32'hFFFE0001 ||
          rsp_id !== 2'(w) || req_ready !== 4'b0 || busy !== 1'b1) begin
        errs++;
        $display("FAIL bp_hold_%0d: vld=%b prod=%h id=%0d rdy=%b busy=%b exp 1 fffe0001 %0d 0000 1",
                 i, rsp_valid, rsp_prod, rsp_id, req_ready, busy, w);
      end
      @(posedge CLK); #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL bp_release: vld=%b busy=%b exp 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  g;
    int          lat;
    logic [1:0]  id;
    logic [31:0] p;
    logic [63:0] av;
    logic [63:0] bv;
    av = '0;
    bv = '0;
    av[15:0] = 16'd7;
    bv[15:0] = 16'd9;
    req_a     = av;
    req_b     = bv;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    req_valid = 4'hF;
    RESETn    = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0 ||
        rsp_prod !== 32'd0 || rsp_id !== 2'd0) begin
      errs++;
      $display("FAIL midrst_async: vld=%b busy=%b rdy=%b prod=%h id=%0d exp all 0",
               rsp_valid, busy, req_ready, rsp_prod, rsp_id);
    end
    repeat (2) @(posedge CLK);
    #1;
    req_valid = '0;
    RESETn    = 1'b1;
    m_ptr     = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL midrst_idle_%0d: vld=%b busy=%b exp 0 0",
                 i, rsp_valid, busy);
      end
    end
    av[31:16] = 16'd11;
    bv[31:16] = 16'd13;
    serve(4'b0011, av, bv, g, lat, id, p);
    checks++;
    if (g !== 4'b0001 || id !== 2'd0 || p !== 32'd63 || lat != 1) begin
      errs++;
      $display("FAIL midrst_after: gnt=%b id=%0d prod=%0d lat=%0d exp 0001 0 63 1",
               g, id, p, lat);
    end
    m_ptr = 1;
  endtask

  task automatic test_zero();
    logic [3:0]  g;
    int          lat;
    logic [1:0]  id;
    logic [31:0] p;
    logic [3:0]  mask;
    int          w;
    mask = 4'($urandom_range(15, 1));
    w    = win(mask, m_ptr);
    serve(mask, 64'd0, {4{16'h1234}}, g, lat, id, p);
    checks++;
    if (g !== onehot(w) || id !== 2'(w) || p !== 32'd0 || lat != 1) begin
      errs++;
      $display("FAIL zero_op: gnt=%b id=%0d prod=%h lat=%0d exp %b %0d 0 1",
               g, id, p, lat, onehot(w), w);
    end
    m_ptr = (w + 1) % 4;
  endtask

  task automatic test_random();
    logic [3:0]  g;
    int          lat;
    logic [1:0]  id;
    logic [31:0] p;
    logic [3:0]  mask;
    logic [63:0] av;
    logic [63:0] bv;
    int          w;
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 4) begin
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== 4'b0 || busy !== 1'b0) begin
          errs++;
          $display("FAIL rand_idle_%0d: rdy=%b busy=%b exp 0000 0",
                   i, req_ready, busy);
        end
        @(posedge CLK); #1;
      end
      mask = 4'($urandom_range(15, 1));
      av   = {$urandom, $urandom};
      bv   = {$urandom, $urandom};
      w    = win(mask, m_ptr);
      serve(mask, av, bv, g, lat, id, p);
      checks++;
      if (g !== onehot(w) || id !== 2'(w) || lat != 1 ||
          p !== lane_prod(av, bv, w)) begin
        errs++;
        $display("FAIL rand_%0d: mask=%b gnt=%b id=%0d lat=%0d prod=%h exp %b %0d 1 %h",
                 i, mask, g, id, lat, p, onehot(w), w, lane_prod(av, bv, w));
      end
      m_ptr = (w + 1) % 4;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_zero();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
